wokwi_395061443288867841: RTL and testbench



---
 rtl/wokwi_395061443288867841_pkg.sv | 37 +++
 rtl/wokwi_395061443288867841_lfsr8_step.sv | 34 +++
 rtl/wokwi_395061443288867841.sv | 97 +++++++++
 tb/tb_wokwi_395061443288867841.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/wokwi_395061443288867841_pkg.sv
// ---------------------------------------------------------------------------
// wokwi_395061443288867841_pkg
//
// Purpose:
//   Shared definitions for the 8-bit pattern generator tile. Holds the mode
//   encoding carried on ui_in[7:6], the LFSR feedback tap mask and the PWM
//   duty shift. It also holds a helper that turns the 6-bit operand into the
//   8-bit PWM compare threshold.
//
// Contents:
//   mode_e          2-bit operating mode (LOAD, COUNT, LFSR, PWM)
//   LFSR_TAPS       feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3)
//   PWM_SHIFT       left shift applied to the operand to form the threshold
//   pwm_threshold   operand -> 8-bit compare value
// ---------------------------------------------------------------------------
package wokwi_395061443288867841_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         PWM_SHIFT = 2;

  // A 6-bit operand shifted left by two fills the 8-bit phase range exactly.
  // D=63 therefore tops out at 252, so the output is never high for a full
  // period.
  function automatic logic [7:0] pwm_threshold(input logic [5:0] d);
    logic [7:0] wide;
    wide = {2'b00, d};
    return wide << PWM_SHIFT;
  endfunction

endpackage

// File: rtl/wokwi_395061443288867841_lfsr8_step.sv
// ---------------------------------------------------------------------------
// lfsr8_step
//
// Purpose:
//   Combinational next-state function of an 8-bit Fibonacci LFSR that shifts
//   left. The period is 255. The all-zero state cannot be reached from any
//   other state. It maps to 0x01 so that a cleared register still starts the
//   sequence.
//
// Ports:
//   cur  input  [7:0]  current register value
//   nxt  output [7:0]  value after one step
// ---------------------------------------------------------------------------
module lfsr8_step
  import wokwi_395061443288867841_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  logic feedback;

  // Feedback is the XOR of the tapped bits. Masking followed by a reduction
  // XOR keeps the tap choice in one place, the package.
  always_comb begin
    feedback = ^(cur & LFSR_TAPS);
    if (cur == 8'h00) begin
      nxt = 8'h01;
    end else begin
      nxt = {cur[6:0], feedback};
    end
  end

endmodule

// File: rtl/wokwi_395061443288867841.sv
// ---------------------------------------------------------------------------
// wokwi_395061443288867841
//
// Purpose:
//   A mode-selectable 8-bit pattern generator microtile. On every rising
//   edge it does one of four things to a working register R: it loads the
//   operand, counts up or down, or steps a maximal-length LFSR. The fourth
//   mode instead emits a PWM waveform derived from a free-running phase
//   counter P. The output comes straight from a register, so there is no
//   combinational path from ui_in to uo_out.
//
// Ports:
//   clk     input        rising-edge clock for all state
//   rst     input        synchronous active-high reset, highest priority
//   ui_in   input  [7:0] [7:6] mode, [5:0] operand D
//   uo_out  output [7:0] registered output
// ---------------------------------------------------------------------------
module wokwi_395061443288867841
  import wokwi_395061443288867841_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  mode_e      mode;
  logic [5:0] operand;

  logic [7:0] r;
  logic [7:0] p;
  logic [7:0] uo_q;

  logic [7:0] r_next;
  logic [7:0] p_next;
  logic [7:0] uo_next;
  logic [7:0] lfsr_next;

  assign mode    = mode_e'(ui_in[7:6]);
  assign operand = ui_in[5:0];
  assign uo_out  = uo_q;

  lfsr8_step u_lfsr8_step (
    .cur (r),
    .nxt (lfsr_next)
  );

  // Next-state mux. P advances in every mode. In the three R-modifying
  // modes the output mirrors the new R. In PWM mode R holds and the output
  // compares against the incremented phase, so that after reset the first
  // PWM decision sees P=1.
  always_comb begin
    p_next  = p + 8'h01;
    r_next  = r;
    uo_next = r;
    case (mode)
      MODE_LOAD: begin
        r_next  = {2'b00, operand};
        uo_next = r_next;
      end
      MODE_COUNT: begin
        if (operand[0]) begin
          r_next = r - 8'h01;
        end else begin
          r_next = r + 8'h01;
        end
        uo_next = r_next;
      end
      MODE_LFSR: begin
        r_next  = lfsr_next;
        uo_next = r_next;
      end
      MODE_PWM: begin
        r_next  = r;
        uo_next = (p_next < pwm_threshold(operand)) ? 8'hFF : 8'h00;
      end
      default: begin
        r_next  = r;
        uo_next = r;
      end
    endcase
  end

  // All state lives here. Reset clears everything regardless of mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r    <= 8'h00;
      p    <= 8'h00;
      uo_q <= 8'h00;
    end else begin
      r    <= r_next;
      p    <= p_next;
      uo_q <= uo_next;
    end
  end

endmodule

// File: tb/tb_wokwi_395061443288867841.sv
// ---------------------------------------------------------------------------
// tb_wokwi_395061443288867841
//
// Purpose:
//   Directed testbench for the pattern generator tile. It drives inputs on
//   the falling edge and samples uo_out 1 time unit after the rising edge.
//   Expected values are hand-derived constants. The PWM checks also use a
//   small phase-counter model.
// ---------------------------------------------------------------------------
module tb_wokwi_395061443288867841;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int         vectors;
  int         miscompares;
  logic [7:0] p_model;

  wokwi_395061443288867841 dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given reset and ui_in values. The phase model
  // follows the DUT phase counter, so p_model is P right after the edge.
  task automatic apply_stimulus(input logic r_in, input logic [7:0] u_in);
    @(negedge clk);
    rst   = r_in;
    ui_in = u_in;
    @(posedge clk);
    #1;
    if (r_in) p_model = 8'h00;
    else      p_model = p_model + 8'h01;
  endtask

  task automatic check_output(input string tag, input logic [7:0] expected);
    vectors++;
    assert (uo_out === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: uo_out=%02h expected=%02h", tag, uo_out, expected);
    end
  endtask

  task automatic check_value(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Runs 256 PWM cycles with operand d. It checks every cycle against the
  // phase model and then checks the total high count.
  task automatic run_pwm(input logic [5:0] d, input int expected_highs, input string tag);
    int         highs;
    logic [7:0] thr;
    highs = 0;
    thr   = {d, 2'b00};
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(1'b0, {2'b11, d});
      check_output(tag, (p_model < thr) ? 8'hFF : 8'h00);
      if (uo_out == 8'hFF) highs++;
    end
    check_value({tag, "_highs"}, highs, expected_highs);
  endtask

  initial begin
    int   saw_zero;
    int   early_return;

    vectors      = 0;
    miscompares  = 0;
    p_model      = 8'h00;
    rst          = 1'b1;
    ui_in        = 8'h00;

    // Reset held for two cycles with junk on ui_in
    apply_stimulus(1'b1, 8'hA5);
    check_output("reset0", 8'h00);
    apply_stimulus(1'b1, 8'h7E);
    check_output("reset1", 8'h00);
    apply_stimulus(1'b0, 8'h00);
    check_output("release_load0", 8'h00);

    // LOAD then COUNT up/down
    apply_stimulus(1'b0, 8'h3F);
    check_output("load3f", 8'h3F);
    apply_stimulus(1'b0, 8'h40);
    check_output("up1", 8'h40);
    apply_stimulus(1'b0, 8'h40);
    check_output("up2", 8'h41);
    apply_stimulus(1'b0, 8'h40);
    check_output("up3", 8'h42);
    apply_stimulus(1'b0, 8'h41);
    check_output("down1", 8'h41);
    // D[5:1] are ignored in COUNT mode
    apply_stimulus(1'b0, 8'h7E);
    check_output("up_ignore_hi", 8'h42);

    // Wrap-around both directions
    apply_stimulus(1'b0, 8'h00);
    check_output("load00", 8'h00);
    apply_stimulus(1'b0, 8'h41);
    check_output("wrap_down", 8'hFF);
    apply_stimulus(1'b0, 8'h40);
    check_output("wrap_up", 8'h00);

    // LFSR from zero: escape to 0x01, then the documented opening sequence
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_escape", 8'h01);
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_s1", 8'h02);
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_s2", 8'h04);
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_s3", 8'h08);
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_s4", 8'h11);

    // The remaining steps of one full period: no zero, no early return to 0x01
    saw_zero     = 0;
    early_return = 0;
    for (int s = 5; s <= 255; s++) begin
      apply_stimulus(1'b0, 8'h80);
      if (uo_out == 8'h00) saw_zero++;
      if (uo_out == 8'h01 && s < 255) early_return++;
    end
    check_output("lfsr_period", 8'h01);
    check_value("lfsr_no_zero", saw_zero, 0);
    check_value("lfsr_no_early", early_return, 0);

    // Reset in the middle of an LFSR run, then the sequence restarts
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_after_period", 8'h02);
    apply_stimulus(1'b1, 8'h80);
    check_output("reset_mid_lfsr", 8'h00);
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_restart0", 8'h01);
    apply_stimulus(1'b0, 8'h80);
    check_output("lfsr_restart1", 8'h02);

    // PWM duty checks; R must hold (0x02) across them
    run_pwm(6'd4, 16, "pwm_d4");
    run_pwm(6'd0, 0, "pwm_d0");
    run_pwm(6'd63, 252, "pwm_d63");
    apply_stimulus(1'b0, 8'h40);
    check_output("r_held_in_pwm", 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
